glb_bank_arbiter: RTL and testbench

- Per-bank access arbiter inside the global buffer tile core.
- Shares one single-port SRAM bank among NUM_REQ requesters: processor router, stream router, store/load DMA and parallel-config DMA.
- Issues at most one bank command per cycle; requesters are served round-robin.
- Carries a requester tag alongside each read so the read response returns to the requester that issued it.

---
 rtl/glb_bank_arbiter.sv | 158 +++++++++++++++
 tb/tb_glb_bank_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_bank_arbiter.sv
// rtl/glb_bank_arbiter.sv - round-robin single-port bank arbiter with tagged read responses
// Optional feature macro: GLB_BANK_ARB_PROC_PRIO_EN (requester 0 gets fixed top priority)
module glb_bank_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_WIDTH      = 17,
  parameter int DATA_WIDTH      = 64,
  parameter int STRB_WIDTH      = 8,
  parameter int BANK_RD_LATENCY = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clk_en,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ*STRB_WIDTH-1:0]    req_strb,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             bank_wr_en,
  output logic                             bank_rd_en,
  output logic [ADDR_WIDTH-1:0]            bank_addr,
  output logic [DATA_WIDTH-1:0]            bank_data,
  output logic [STRB_WIDTH-1:0]            bank_strb,
  input  logic [DATA_WIDTH-1:0]            bank_rd_data,
  output logic [NUM_REQ-1:0]               rdrs_valid,
  output logic [DATA_WIDTH-1:0]            rdrs_data,
  output logic                             busy
);

  localparam int TAG_W  = $clog2(NUM_REQ);
  localparam int PIPE_D = BANK_RD_LATENCY + 1;
  localparam logic [TAG_W:0] NUM_REQ_W = (TAG_W+1)'(NUM_REQ);

  logic [TAG_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [TAG_W-1:0]      gnt_idx;
  logic [TAG_W:0]        cand;
  logic                  gnt_found;

  logic                  wr_en_q, rd_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic [TAG_W-1:0]      tag_q;

  logic                  pipe_vld_q [PIPE_D];
  logic [TAG_W-1:0]      pipe_tag_q [PIPE_D];
  logic [DATA_WIDTH-1:0] rdrs_data_q;

  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [STRB_WIDTH-1:0] sel_strb;

  // Grant search: first valid requester after rr_ptr, wrapping; blocked while stalled or in reset
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (TAG_W+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
`ifdef GLB_BANK_ARB_PROC_PRIO_EN
      if (!gnt_found && (cand != '0) && req_valid[cand[TAG_W-1:0]]) begin
`else
      if (!gnt_found && req_valid[cand[TAG_W-1:0]]) begin
`endif
        gnt_found = 1'b1;
        gnt_idx   = cand[TAG_W-1:0];
      end
    end
`ifdef GLB_BANK_ARB_PROC_PRIO_EN
    // Processor overrides the rotation and leaves the pointer alone
    if (req_valid[0]) begin
      gnt_found = 1'b1;
      gnt_idx   = '0;
    end
`endif
    if (!clk_en || reset) gnt_found = 1'b0;
    req_ready = '0;
    if (gnt_found) req_ready[gnt_idx] = 1'b1;
    rr_ptr_d = rr_ptr_q;
`ifdef GLB_BANK_ARB_PROC_PRIO_EN
    if (gnt_found && (gnt_idx != '0)) rr_ptr_d = gnt_idx;
`else
    if (gnt_found) rr_ptr_d = gnt_idx;
`endif
  end

  assign sel_wr   = req_wr[gnt_idx];
  assign sel_addr = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data = req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_strb = req_strb[gnt_idx*STRB_WIDTH +: STRB_WIDTH];

  // Command stage register and pointer update; everything holds while clk_en is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= TAG_W'(NUM_REQ-1);
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      tag_q    <= '0;
    end else if (clk_en) begin
      rr_ptr_q <= rr_ptr_d;
      wr_en_q  <= gnt_found & sel_wr;
      rd_en_q  <= gnt_found & ~sel_wr;
      if (gnt_found) begin
        addr_q <= sel_addr;
        data_q <= sel_data;
        strb_q <= sel_strb;
        tag_q  <= gnt_idx;
      end
    end
  end

  // Tag pipeline tracks each bank read across the SRAM latency plus the response register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_D; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_tag_q[i] <= '0;
      end
    end else if (clk_en) begin
      pipe_vld_q[0] <= rd_en_q;
      pipe_tag_q[0] <= tag_q;
      for (int i = 1; i < PIPE_D; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
    end
  end

  // Response data register captures bank output the cycle it becomes valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdrs_data_q <= '0;
    end else if (clk_en && pipe_vld_q[BANK_RD_LATENCY-1]) begin
      rdrs_data_q <= bank_rd_data;
    end
  end

  // Response valid decode and in-flight indication
  always_comb begin
    rdrs_valid = '0;
    if (pipe_vld_q[PIPE_D-1]) rdrs_valid[pipe_tag_q[PIPE_D-1]] = 1'b1;
    busy = wr_en_q | rd_en_q;
    for (int i = 0; i < PIPE_D; i++) busy = busy | pipe_vld_q[i];
  end

  assign bank_wr_en = wr_en_q & clk_en;
  assign bank_rd_en = rd_en_q & clk_en;
  assign bank_addr  = addr_q;
  assign bank_data  = data_q;
  assign bank_strb  = strb_q;
  assign rdrs_data  = rdrs_data_q;

endmodule

// File: tb/tb_glb_bank_arbiter.sv
// tb/tb_glb_bank_arbiter.sv - scoreboard bench with reference model for glb_bank_arbiter
module tb_glb_bank_arbiter;
  localparam int N   = 4;
  localparam int AW  = 17;
  localparam int DW  = 64;
  localparam int SW  = 8;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, clk_en;
  logic [N-1:0]    req_valid, req_wr, req_ready, rdrs_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N*SW-1:0] req_strb;
  logic            bank_wr_en, bank_rd_en, busy;
  logic [AW-1:0]   bank_addr;
  logic [DW-1:0]   bank_data, bank_rd_data, rdrs_data;
  logic [SW-1:0]   bank_strb;

  glb_bank_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW),
                     .BANK_RD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
    .req_strb(req_strb), .req_ready(req_ready),
    .bank_wr_en(bank_wr_en), .bank_rd_en(bank_rd_en), .bank_addr(bank_addr),
    .bank_data(bank_data), .bank_strb(bank_strb), .bank_rd_data(bank_rd_data),
    .rdrs_valid(rdrs_valid), .rdrs_data(rdrs_data), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] init_word(input int i);
    return 64'hDEAD_BEEF_0000_0000 + 64'(i) - 64'd7;
  endfunction

  // Environment SRAM: 16 words, gated by clk_en, fixed read latency
  logic          primed = 1'b0;
  logic [DW-1:0] sram  [16];
  logic [DW-1:0] bpipe [LAT];
  always @(posedge clk) begin
    if (!primed) begin
      for (int i = 0; i < 16; i++) sram[i] <= init_word(i);
      for (int i = 0; i < LAT; i++) bpipe[i] <= '0;
      primed <= 1'b1;
    end else if (clk_en) begin
      if (bank_wr_en)
        for (int b = 0; b < SW; b++)
          if (bank_strb[b]) sram[bank_addr[6:3]][8*b +: 8] <= bank_data[8*b +: 8];
      bpipe[0] <= bank_rd_en ? sram[bank_addr[6:3]] : '0;
      for (int i = 1; i < LAT; i++) bpipe[i] <= bpipe[i-1];
    end
  end
  assign bank_rd_data = bpipe[LAT-1];

  // Enabled-cycle counter: latency is measured in cycles the block actually advances
  int ecyc = 0;
  always @(posedge clk) if (clk_en && !reset) ecyc <= ecyc + 1;

  // Reference model state
  typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; logic [SW-1:0] strb; int due; } cmd_t;
  typedef struct { int tag; logic [DW-1:0] data; int due; } rsp_t;
  cmd_t          cmd_q [$];
  rsp_t          rsp_q [$];
  int            rr;
  logic [DW-1:0] ref_mem [16];
  int            gcount [N];
  logic          fix_strb = 1'b0;
  int            fix_addr = -1;

  function automatic int model_grant(input logic [N-1:0] v);
`ifdef GLB_BANK_ARB_PROC_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (rr + k) % N;
`ifdef GLB_BANK_ARB_PROC_PRIO_EN
      if (i == 0) continue;
`endif
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] w, input logic ce);
    int g, a;
    logic [N-1:0] exp_rdy;
    req_valid = v;
    req_wr    = w;
    clk_en    = ce;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = (fix_addr >= 0) ? AW'(fix_addr) : AW'($urandom_range(0, 15) * 8);
      req_data[i*DW +: DW] = {$urandom, $urandom};
      req_strb[i*SW +: SW] = fix_strb ? 8'hFF : SW'($urandom);
    end
    @(negedge clk);
    g = (ce && !reset) ? model_grant(v) : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("grant", 64'(req_ready), 64'(exp_rdy));
    for (int i = 0; i < N; i++) if (req_ready[i]) gcount[i]++;
    if (g >= 0) begin
      a = int'(req_addr[g*AW +: AW]) / 8;
      cmd_q.push_back('{wr: w[g], addr: req_addr[g*AW +: AW], data: req_data[g*DW +: DW],
                        strb: req_strb[g*SW +: SW], due: ecyc + 1});
      if (w[g]) begin
        for (int b = 0; b < SW; b++)
          if (req_strb[g*SW + b]) ref_mem[a][8*b +: 8] = req_data[g*DW + 8*b +: 8];
      end else begin
        rsp_q.push_back('{tag: g, data: ref_mem[a], due: ecyc + LAT + 2});
      end
`ifdef GLB_BANK_ARB_PROC_PRIO_EN
      if (g != 0) rr = g;
`else
      rr = g;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    clk_en = 1'b1;
    cmd_q.delete();
    rsp_q.delete();
    rr = N - 1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a command or a response
  logic [DW-1:0] last_rd = '0;
  cmd_t mc;
  rsp_t mr;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        last_rd = '0;
      end else if (clk_en) begin
        if (bank_wr_en || bank_rd_en) begin
          if (cmd_q.size() == 0) begin
            check("unexpected_cmd", {62'd0, bank_wr_en, bank_rd_en}, 64'd0);
          end else begin
            mc = cmd_q.pop_front();
            check("cmd_kind", {62'd0, bank_wr_en, bank_rd_en}, {62'd0, mc.wr, ~mc.wr});
            check("cmd_addr", 64'(bank_addr), 64'(mc.addr));
            check("cmd_time", 64'(ecyc), 64'(mc.due));
            if (mc.wr) begin
              check("cmd_data", bank_data, mc.data);
              check("cmd_strb", 64'(bank_strb), 64'(mc.strb));
            end
          end
        end
        if (rdrs_valid != '0) begin
          if (rsp_q.size() == 0) begin
            check("unexpected_rsp", 64'(rdrs_valid), 64'd0);
          end else begin
            mr = rsp_q.pop_front();
            check("rsp_tag", 64'(rdrs_valid), 64'(1) << mr.tag);
            check("rsp_data", rdrs_data, mr.data);
            check("rsp_time", 64'(ecyc), 64'(mr.due));
            last_rd = mr.data;
          end
        end else begin
          check("rsp_hold", rdrs_data, last_rd);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    for (int i = 0; i < N; i++) gcount[i] = 0;
    rr = N - 1;
    reset = 1'b1;
    clk_en = 1'b1;
    req_valid = '1;
    req_wr = '0;
    req_addr = '0;
    req_data = '0;
    req_strb = '0;
    @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_wr_en", 64'(bank_wr_en), 64'd0);
    check("rst_rd_en", 64'(bank_rd_en), 64'd0);
    check("rst_addr", 64'(bank_addr), 64'd0);
    check("rst_rdrs_valid", 64'(rdrs_valid), 64'd0);
    check("rst_rdrs_data", rdrs_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single read from requester 1 at 0x40
    fix_addr = 'h40;
    step(4'b0010, 4'b0000, 1'b1);
    fix_addr = -1;
    idle(6);

    // Fairness from reset with everybody valid
    do_reset();
    for (int i = 0; i < N; i++) gcount[i] = 0;
    for (int k = 0; k < 8; k++) step(4'b1111, 4'($urandom), 1'b1);
`ifdef GLB_BANK_ARB_PROC_PRIO_EN
    check("fair_req0", 64'(gcount[0]), 64'd8);
    check("fair_req1", 64'(gcount[1]), 64'd0);
`else
    for (int i = 0; i < N; i++) check("fair_count", 64'(gcount[i]), 64'd2);
`endif
    idle(6);

    // Alternating write (req 2) / read (req 3) stream
    fix_strb = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(4'b0100, 4'b0100, 1'b1);
      step(4'b1000, 4'b0000, 1'b1);
    end
    fix_strb = 1'b0;
    idle(6);

    // Three-cycle clock-enable stall with a read in flight
    step(4'b0100, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b1111, 4'b0000, 1'b0);
    check("stall_busy", 64'(busy), 64'd1);
    step(4'b1111, 4'b0000, 1'b0);
    step(4'b1111, 4'b0000, 1'b0);
    idle(8);

    // Reset one cycle after a read is accepted
    step(4'b0001, 4'b0000, 1'b1);
    reset = 1'b1;
    cmd_q.delete();
    rsp_q.delete();
    rr = N - 1;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'd0);
    check("midrst_rdrs", 64'(rdrs_valid), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(6);
    check("midrst_idle_busy", 64'(busy), 64'd0);
    for (int i = 0; i < N; i++) gcount[i] = 0;
    step(4'b1111, 4'b0000, 1'b1);
    check("midrst_first_grant0", 64'(gcount[0]), 64'd1);
    idle(6);

`ifdef GLB_BANK_ARB_PROC_PRIO_EN
    // Processor priority: req 0 wins while valid, then rotation resumes
    do_reset();
    for (int i = 0; i < N; i++) gcount[i] = 0;
    for (int k = 0; k < 4; k++) step(4'b0011, 4'b0000, 1'b1);
    check("prio_req0", 64'(gcount[0]), 64'd4);
    step(4'b0110, 4'b0000, 1'b1);
    step(4'b0110, 4'b0000, 1'b1);
    check("prio_req1", 64'(gcount[1]), 64'd1);
    check("prio_req2", 64'(gcount[2]), 64'd1);
    idle(6);
`endif

    // Randomized traffic with occasional stalls
    for (int k = 0; k < 600; k++)
      step(4'($urandom), 4'($urandom), ($urandom_range(0, 9) != 0));
    idle(10);

    check("end_cmd_q_empty", 64'(cmd_q.size()), 64'd0);
    check("end_rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    check("end_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
